// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: shared definitions for the multi-channel timer.
//   reg_e         - register offset within a channel (address[1:0])
//   chan_state_t  - per-channel RUN/TO state, exported for debug/checkers
//   STAT_*/CTRL_* - bit positions inside STATUS and CONTROL
//   PS_*          - prescaler field range inside CONTROL
//   status_word / control_word - pack channel fields into 32-bit read words
package multi_timer_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_e;

  typedef struct packed {
    logic run;
    logic to;
  } chan_state_t;

  localparam int STAT_TO    = 0;
  localparam int STAT_RUN   = 1;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int PS_LSB     = 8;
  localparam int PS_MSB     = 15;
  localparam int PS_W       = PS_MSB - PS_LSB + 1;

  function automatic logic [31:0] status_word(input chan_state_t st);
    logic [31:0] w;
    w           = '0;
    w[STAT_TO]  = st.to;
    w[STAT_RUN] = st.run;
    return w;
  endfunction

  // START/STOP are strobes and are never stored, so they read back as 0.
  function automatic logic [31:0] control_word(input logic ito, input logic cont,
                                               input logic [PS_W-1:0] ps);
    logic [31:0] w;
    w                = '0;
    w[CTRL_ITO]      = ito;
    w[CTRL_CONT]     = cont;
    w[PS_MSB:PS_LSB] = ps;
    return w;
  endfunction

endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if: Avalon-MM slave bus of the multi-channel timer.
//   address    - {channel, register}
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - registered read data
// Handshake: fixed-latency, no waitrequest. A write is accepted in every
// cycle where chipselect && !write_n is sampled on the rising clock edge.
// readdata always reflects the register addressed in the previous cycle,
// whether or not chipselect was asserted.
interface multi_timer_if #(
  parameter int NUM_CH = 4
);
  localparam int AW = $clog2(NUM_CH) + 2;

  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/multi_timer_channel.sv
// timer_channel: one independent down-counting timer channel.
//   clk, reset_n         - clock, asynchronous active-low reset
//   status_we/ctrl_we/
//   period_we/snap_we    - decoded register write strobes for this channel
//   wdata                - bus write data
//   state                - RUN/TO state
//   ito, cont, ps        - stored CONTROL fields
//   period, snap         - PERIOD register (period-1) and captured count
//   tick                 - one-cycle pulse on each timeout
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 143000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             status_we,
  input  logic             ctrl_we,
  input  logic             period_we,
  input  logic             snap_we,
  input  logic [31:0]      wdata,
  output chan_state_t      state,
  output logic             ito,
  output logic             cont,
  output logic [PS_W-1:0]  ps,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic             tick
);

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(DEFAULT_PERIOD - 1);

  logic [CNT_W-1:0] count;
  logic [PS_W-1:0]  pre;
  logic             start;
  logic             stop;
  logic             step;
  logic             expire;

  assign start  = ctrl_we && wdata[CTRL_START];
  assign stop   = ctrl_we && wdata[CTRL_STOP];
  // The counter moves only when the prescaler has run down to zero.
  assign step   = state.run && (pre == '0);
  assign expire = step && (count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= RST_VAL;
      period <= RST_VAL;
      pre    <= '0;
      ito    <= 1'b0;
      cont   <= 1'b0;
      ps     <= '0;
      state  <= '0;
      snap   <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= expire;

      // A timeout outranks a same-cycle STATUS clear so no event is lost.
      if (expire) begin
        state.to <= 1'b1;
      end else if (status_we) begin
        state.to <= 1'b0;
      end

      if (snap_we) begin
        snap <= count;
      end

      if (ctrl_we) begin
        ito  <= wdata[CTRL_ITO];
        cont <= wdata[CTRL_CONT];
        ps   <= wdata[PS_MSB:PS_LSB];
      end

      if (period_we) begin
        // Force reload: new period takes effect at once, the prescaler
        // restarts a full PS+1 interval and the channel waits for START.
        period    <= wdata[CNT_W-1:0];
        count     <= wdata[CNT_W-1:0];
        pre       <= ps;
        state.run <= 1'b0;
      end else begin
        if (step) begin
          pre   <= ps;
          count <= expire ? period : count - CNT_W'(1);
        end else if (state.run) begin
          pre <= pre - PS_W'(1);
        end

        if (start) begin
          state.run <= 1'b1;
        end else if (stop || (expire && !cont)) begin
          state.run <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent timers behind an Avalon-MM slave.
//   clk, reset_n - clock, asynchronous active-low reset
//   bus          - Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   irq          - OR over channels of (TO && ITO)
//   tick         - per-channel one-cycle timeout pulse
// Holds address decode, the registered read mux and the irq OR.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 143000
) (
  input  logic              clk,
  input  logic              reset_n,
  multi_timer_if.slave      bus,
  output logic              irq,
  output logic [NUM_CH-1:0] tick
);

  localparam int AW = $clog2(NUM_CH) + 2;

  logic [AW-1:0]            ch_sel;
  reg_e                     reg_sel;
  logic                     wr;
  logic [NUM_CH-1:0][31:0]  rd_val;
  logic [NUM_CH-1:0]        irq_vec;
  logic [31:0]              rd_next;

  // Shift rather than slice so NUM_CH=1 (no channel bits) still works.
  assign ch_sel  = bus.address >> 2;
  assign reg_sel = reg_e'(bus.address[1:0]);
  assign wr      = bus.chipselect && !bus.write_n;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             hit;
    chan_state_t      state;
    logic             ito;
    logic             cont;
    logic [PS_W-1:0]  ps;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] snap;
    logic [31:0]      rv;

    assign hit = wr && (ch_sel == AW'(c));

    timer_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .status_we (hit && (reg_sel == REG_STATUS)),
      .ctrl_we   (hit && (reg_sel == REG_CONTROL)),
      .period_we (hit && (reg_sel == REG_PERIOD)),
      .snap_we   (hit && (reg_sel == REG_SNAP)),
      .wdata     (bus.writedata),
      .state     (state),
      .ito       (ito),
      .cont      (cont),
      .ps        (ps),
      .period    (period),
      .snap      (snap),
      .tick      (tick[c])
    );

    always_comb begin
      rv = '0;
      case (reg_sel)
        REG_STATUS:  rv = status_word(state);
        REG_CONTROL: rv = control_word(ito, cont, ps);
        REG_PERIOD:  rv = 32'(period);
        REG_SNAP:    rv = 32'(snap);
        default:     rv = '0;
      endcase
    end

    assign rd_val[c]  = rv;
    assign irq_vec[c] = state.to && ito;
  end

  // Channel numbers with no instance fall through and read 0.
  always_comb begin
    rd_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == AW'(c)) rd_next = rd_val[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed self-checking bench for multi_timer.
module tb_multi_timer;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int DEF_P  = 143000;
  localparam int ST = 0, CT = 1, PR = 2, SN = 3;

  // clock / reset
  logic              clk = 1'b0;
  logic              reset_n;
  logic              irq;
  logic [NUM_CH-1:0] tick;
  int                cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_timer_if #(.NUM_CH(NUM_CH)) bus();

  multi_timer #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEF_P)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq),
    .tick    (tick)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic bus_write_at(input int ch, input int r, input logic [31:0] d,
                              output int edge_idx);
    @(negedge clk);
    bus.address    = 4'(ch * 4 + r);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    edge_idx       = cyc;
  endtask

  task automatic bus_write(input int ch, input int r, input logic [31:0] d);
    int unused_edge;
    bus_write_at(ch, r, d, unused_edge);
  endtask

  task automatic read_raw(input int ch, input int r, output logic [31:0] got);
    @(negedge clk);
    bus.address = 4'(ch * 4 + r);
    @(negedge clk);
    got = bus.readdata;
  endtask

  task automatic expect_read(input string tag, input int ch, input int r,
                             input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    read_raw(ch, r, got);
    check(tag, got, exp_q.pop_front());
  endtask

  // Cycles from now until tick[ch]; 0 if it never arrives within the budget.
  task automatic expect_tick(input string tag, input int ch, input int exp_n);
    logic [31:0] got;
    exp_q.push_back(32'(exp_n));
    got = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (tick[ch]) begin
        got = 32'(i);
        break;
      end
    end
    check(tag, got, exp_q.pop_front());
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic [NUM_CH-1:0] seen;
    seen = '0;
    repeat (n) begin
      @(negedge clk);
      seen |= tick;
    end
    check(tag, 32'(seen), 32'h0);
  endtask

  // stimulus
  initial begin
    int          s0;
    int          es;
    logic [31:0] rd;
    logic [31:0] exp_snap;

    reset_n        = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (3) @(negedge clk);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    reset_n = 1'b1;

    expect_read("rst_period", 0, PR, 32'(DEF_P - 1));
    expect_read("rst_ctrl", 1, CT, 32'h0);
    expect_read("rst_status", 3, ST, 32'h0);
    expect_read("rst_snap", 2, SN, 32'h0);
    expect_quiet("idle_after_reset", 20);

    // ch0 continuous: PERIOD=4, PS=0 -> tick every 5 cycles
    bus_write(0, CT, 32'h3);
    bus_write(0, PR, 32'd4);
    bus_write(0, CT, 32'h7);
    expect_tick("cont_first", 0, 5);
    check("cont_irq_first", 32'(irq), 32'h1);
    expect_tick("cont_second", 0, 5);
    expect_tick("cont_third", 0, 5);
    expect_read("cont_status", 0, ST, 32'h3);
    bus_write(0, CT, 32'h9);
    bus_write(0, ST, 32'h0);
    expect_read("cont_status_clr", 0, ST, 32'h0);
    check("cont_irq_clr", 32'(irq), 32'h0);

    // ch1 one-shot: PERIOD=2, PS=3 -> single tick 12 cycles after START
    bus_write(1, CT, 32'h300);
    bus_write(1, PR, 32'd2);
    bus_write(1, CT, 32'h304);
    expect_tick("oneshot_tick", 1, 12);
    expect_quiet("oneshot_single", 40);
    expect_read("oneshot_status", 1, ST, 32'h1);
    check("oneshot_no_irq", 32'(irq), 32'h0);
    bus_write(1, ST, 32'h0);

    // ch1 PERIOD=0 continuous -> timeout on every step
    bus_write(1, CT, 32'h2);
    bus_write(1, PR, 32'd0);
    bus_write(1, CT, 32'h6);
    expect_tick("p0_first", 1, 1);
    expect_tick("p0_second", 1, 1);
    bus_write(1, CT, 32'h8);
    bus_write(1, ST, 32'h0);

    // ch2 force reload while running
    bus_write(2, CT, 32'h2);
    bus_write(2, PR, 32'd9);
    bus_write(2, CT, 32'h6);
    repeat (3) @(negedge clk);
    bus_write(2, PR, 32'd3);
    expect_read("reload_run", 2, ST, 32'h0);
    bus_write(2, SN, 32'h0);
    expect_read("reload_count", 2, SN, 32'd3);
    bus_write(2, CT, 32'h6);
    expect_tick("reload_tick", 2, 4);
    bus_write(2, CT, 32'h8);
    bus_write(2, ST, 32'h0);

    // ch3 STATUS write lands on the timeout edge
    bus_write(3, CT, 32'h3);
    bus_write(3, PR, 32'd4);
    bus_write(3, CT, 32'h7);
    repeat (3) @(negedge clk);
    bus_write(3, ST, 32'h0);
    check("race_tick_aligned", 32'(tick[3]), 32'h1);
    expect_read("race_to_kept", 3, ST, 32'h3);
    check("race_irq_kept", 32'(irq), 32'h1);
    bus_write(3, CT, 32'h9);
    bus_write(3, ST, 32'h0);
    expect_read("race_to_cleared", 3, ST, 32'h0);
    check("race_irq_cleared", 32'(irq), 32'h0);

    // START and STOP together: start wins; strobes read back 0
    bus_write(3, CT, 32'h50F);
    expect_read("ctrl_readback", 3, CT, 32'h503);
    read_raw(3, ST, rd);
    check("start_wins", rd & 32'h2, 32'h2);
    bus_write(3, CT, 32'h8);
    bus_write(3, ST, 32'h0);

    // multi-channel: ch0 PERIOD=7 (ITO), ch2 PERIOD=2 (no ITO), SNAP ch0
    bus_write(0, CT, 32'h3);
    bus_write(0, PR, 32'd7);
    bus_write_at(0, CT, 32'h7, s0);
    bus_write(2, CT, 32'h2);
    bus_write(2, PR, 32'd2);
    bus_write(2, CT, 32'h6);
    repeat ($urandom_range(0, 12)) @(negedge clk);
    bus_write_at(0, SN, 32'h0, es);
    exp_snap = 32'(7 - ((es - 1 - s0) % 8));
    expect_read("multi_snap", 0, SN, exp_snap);
    expect_read("multi_ch1_idle", 1, ST, 32'h0);
    expect_read("multi_ch3_idle", 3, ST, 32'h0);
    expect_read("multi_ch3_snap", 3, SN, 32'h0);
    expect_read("multi_ch2_snap_kept", 2, SN, 32'd3);
    repeat (10) @(negedge clk);
    check("multi_irq_ch0", 32'(irq), 32'h1);
    bus_write(0, CT, 32'h9);
    bus_write(0, ST, 32'h0);
    check("multi_irq_masked", 32'(irq), 32'h0);
    expect_read("multi_ch2_status", 2, ST, 32'h3);

    // asynchronous reset mid-count
    @(negedge clk);
    bus.address = 4'(2 * 4 + ST);
    @(negedge clk);
    check("pre_reset_readdata", bus.readdata, 32'h3);
    #2 reset_n = 1'b0;
    #1;
    check("async_readdata", bus.readdata, 32'h0);
    check("async_irq", 32'(irq), 32'h0);
    check("async_tick", 32'(tick), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    expect_read("post_rst_period", 0, PR, 32'(DEF_P - 1));
    expect_read("post_rst_status", 2, ST, 32'h0);
    expect_read("post_rst_ctrl", 2, CT, 32'h0);
    expect_read("post_rst_snap", 0, SN, 32'h0);
    expect_quiet("post_rst_quiet", 30);

    check("queue_empty", 32'(exp_q.size()), 32'h0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent timer channels (legal range 1..8).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the counter and period width in bits (legal range 8..32).
REQ-003 SHALL have parameter DEFAULT_PERIOD, default 143000, meaning the reset period of every channel (counter loads DEFAULT_PERIOD-1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port address, input, clog2(NUM_CH)+2 bits: upper bits = channel c, low 2 bits = register r.
REQ-007 SHALL have port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-008 SHALL have port write_n, input, 1 bit: active-low write strobe; write = chipselect && !write_n.
REQ-009 SHALL have port writedata, input, 32 bits: write data.
REQ-010 SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 SHALL have port irq, output, 1 bit: OR over all channels of (TO && ITO).
REQ-012 SHALL have port tick, output, NUM_CH bits: per-channel one-cycle pulse on each timeout event.

Function
REQ-013 SHALL decode r=0 STATUS (bit0 TO, bit1 RUN; any write clears TO), r=1 CONTROL (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP, bits[15:8] PS), r=2 PERIOD (CNT_W bits, holds period-1), r=3 SNAP (any write captures counter; read returns capture).
REQ-014 SHALL store CONTROL bits 0,1 and 15:8; START/STOP are write-only strobes that read back 0.
REQ-015 SHALL register readdata one cycle after the address is presented, independent of chipselect; unused bits and addresses of channels >= NUM_CH SHALL read 0.
REQ-016 SHALL run a per-channel prescaler: when RUN, prescaler counts PS..0; the counter advances one step on each prescaler zero, so PS=0 decrements every cycle and PS=n every n+1 cycles.
REQ-017 SHALL, on a counter step at count 0, reload PERIOD, assert tick[c] for exactly one cycle, and set TO; if CONT=0 it SHALL also clear RUN (one-shot).
REQ-018 SHALL, one cycle after a PERIOD write, load the counter with the new PERIOD, reset the prescaler and clear RUN (force reload).
REQ-019 SHALL set RUN on START; START and STOP in the same write SHALL give RUN=1 (start wins).
REQ-020 SHALL hold counter and prescaler while RUN=0; START resumes from the held value.
REQ-021 SHALL give TO set priority over a same-cycle STATUS write clear, so no timeout event is lost.
REQ-022 SHALL, with PERIOD=0 and CONT=1, time out on every counter step.
REQ-023 SHALL keep channels fully independent; a write to channel c SHALL affect no other channel.

Reset
REQ-024 SHALL on reset_n low, immediately: counter=DEFAULT_PERIOD-1, PERIOD=DEFAULT_PERIOD-1, prescaler=0, CONTROL=0, TO=0, RUN=0, SNAP=0, readdata=0, tick=0, irq=0.
REQ-025 SHALL, after reset deassertion, keep every channel stopped until START is written.

Structure
REQ-026 SHALL place register offsets (STATUS/CONTROL/PERIOD/SNAP), control bit positions and the PS field range in package multi_timer_pkg.
REQ-027 SHALL implement one channel (counter, prescaler, RUN/TO, SNAP, tick) as sub-module timer_channel, instantiated NUM_CH times in a generate loop; the top level holds decode, the read mux and the irq OR.

Verification
REQ-028 SHALL cover: PERIOD=4, PS=0, CONT=1, ITO=1, START -> tick every 5 cycles; TO and irq set on the first tick.
REQ-029 SHALL cover: PERIOD=2, PS=3, CONT=0, START -> exactly one tick 12 cycles after START; RUN reads 0 afterwards.
REQ-030 SHALL cover: PERIOD=9 running; write PERIOD=3 -> RUN=0 next cycle and counter=3; START -> tick after 4 cycles.
REQ-031 SHALL cover: STATUS write in the same cycle as a timeout -> TO stays 1; a later STATUS write -> TO=0, irq=0.
REQ-032 SHALL cover: NUM_CH=4, start ch0 PERIOD=7 and ch2 PERIOD=2; SNAP write to ch0 at a known cycle -> read SNAP matches the model, ch1 and ch3 stay idle, and irq is the OR of the ITO-enabled channels.
REQ-033 SHALL cover: reset_n pulsed low mid-count -> all fields at reset values asynchronously; no tick until START.
